// File: rtl/display_buffer_ctrl_if.sv
// Request channel from the stack calculator core to the display buffer controller.
// The master drives a request and holds it until the slave raises req_ready.
interface display_buffer_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [3:0] req_code;

  modport master (
    output req_valid,
    output req_cmd,
    output req_code,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_cmd,
    input  req_code,
    output req_ready
  );
endinterface

// File: rtl/display_buffer_ctrl.sv
// Shadow/displayed symbol buffer controller for the VGA text picture generator.
// Edits land in a shadow buffer that is copied to the displayed buffer at the start of vblank.
module display_buffer_ctrl #(
  parameter int unsigned MAX_SYMBOLS = 96,
  parameter int unsigned CNT_W       = 7,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic                     clk,
  input  logic                     reset,
  display_buffer_ctrl_if.slave     req,
  input  logic                     vblank,
  output logic [4*MAX_SYMBOLS-1:0] numbers,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     dirty
);

  localparam int unsigned        BufW     = 4 * MAX_SYMBOLS;
  localparam logic [CNT_W-1:0]   MaxCnt   = CNT_W'(MAX_SYMBOLS);
  localparam logic [CNT_W-1:0]   LastIdx  = CNT_W'(MAX_SYMBOLS - 1);
  localparam logic [BufW-1:0]    BlankBuf = {MAX_SYMBOLS{BLANK_CODE}};
  localparam logic [1:0]         CmdAppend    = 2'b00;
  localparam logic [1:0]         CmdBackspace = 2'b01;
  localparam logic [1:0]         CmdClear     = 2'b10;

  typedef enum logic [1:0] {StIdle, StClear, StCommit} state_e;

  state_e           state_q, state_d;
  logic [BufW-1:0]  shadow_q, shadow_d;
  logic [BufW-1:0]  numbers_q, numbers_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             dirty_q, dirty_d;
  logic             pending_q, pending_d;
  logic             vblank_q;
  logic             rise;
  logic             accept;
  logic [CNT_W+1:0] slot_sel;

  assign rise = vblank & ~vblank_q;

  // A qualifying vblank rise wins over a request presented in the same cycle.
  assign req.req_ready = ~reset & (state_q == StIdle) & ~(rise & dirty_q);
  assign accept        = req.req_valid & req.req_ready;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    numbers_d = numbers_q;
    count_d   = count_q;
    idx_d     = idx_q;
    dirty_d   = dirty_q;
    pending_d = pending_q;
    slot_sel  = '0;

    unique case (state_q)
      StIdle: begin
        if (rise && dirty_q) begin
          state_d = StCommit;
        end else if (accept) begin
          case (req.req_cmd)
            CmdAppend: begin
              if (count_q < MaxCnt) begin
                slot_sel               = {count_q, 2'b00};
                shadow_d[slot_sel +: 4] = req.req_code;
                count_d                = count_q + 1'b1;
                dirty_d                = 1'b1;
              end
            end
            CmdBackspace: begin
              if (count_q != '0) begin
                slot_sel               = {count_q - 1'b1, 2'b00};
                shadow_d[slot_sel +: 4] = BLANK_CODE;
                count_d                = count_q - 1'b1;
                dirty_d                = 1'b1;
              end
            end
            CmdClear: begin
              state_d = StClear;
              idx_d   = '0;
            end
            default: ;
          endcase
        end
      end

      StClear: begin
        slot_sel               = {idx_q, 2'b00};
        shadow_d[slot_sel +: 4] = BLANK_CODE;
        if (rise) pending_d = 1'b1;
        if (idx_q == LastIdx) begin
          count_d   = '0;
          dirty_d   = 1'b1;
          pending_d = 1'b0;
          // A rise seen while clearing is serviced before any new request.
          state_d   = (pending_q || rise) ? StCommit : StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StCommit: begin
        numbers_d = shadow_q;
        dirty_d   = 1'b0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      shadow_q  <= BlankBuf;
      numbers_q <= BlankBuf;
      count_q   <= '0;
      idx_q     <= '0;
      dirty_q   <= 1'b0;
      pending_q <= 1'b0;
      vblank_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      numbers_q <= numbers_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      pending_q <= pending_d;
      vblank_q  <= vblank;
    end
  end

  assign numbers = numbers_q;
  assign count   = count_q;
  assign full    = (count_q == MaxCnt);
  assign dirty   = dirty_q;

endmodule

// File: tb/tb_display_buffer_ctrl.sv
// Self-checking bench for display_buffer_ctrl: directed edits, commits, clear and reset cases.
// Expected commit images are queued by the stimulus and checked by a commit monitor.
module tb_display_buffer_ctrl;

  localparam int BufW = 384;

  logic            clk = 1'b0;
  logic            reset;
  logic            vblank;
  logic [BufW-1:0] numbers;
  logic [6:0]      count;
  logic            full;
  logic            dirty;

  display_buffer_ctrl_if bus ();

  display_buffer_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.slave),
    .vblank  (vblank),
    .numbers (numbers),
    .count   (count),
    .full    (full),
    .dirty   (dirty)
  );

  always #5 clk = ~clk;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [BufW-1:0] exp_q[$];
  logic            dirty_prev = 1'b0;

  task automatic check(input string name, input logic [BufW-1:0] act,
                       input logic [BufW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A commit is the only event that drops dirty outside of reset.
  always @(negedge clk) begin
    if (reset) begin
      dirty_prev = dirty;
    end else begin
      if (dirty_prev && !dirty) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_commit: got %0h expected no commit", numbers);
        end else begin
          check("commit_numbers", numbers, exp_q.pop_front());
        end
      end
      dirty_prev = dirty;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends just after a rising edge.
  task automatic send(input logic [1:0] cmd, input logic [3:0] code, output bit acc);
    acc           = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_code  = code;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
      step();
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 300 cycles");
    end else begin
      step();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic append(input logic [3:0] code);
    bit acc;
    send(2'b00, code, acc);
  endtask

  task automatic backspace();
    bit acc;
    send(2'b01, 4'h0, acc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vblank = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_ready_low", bus.req_ready, 0);
    check("rst_numbers", numbers, {96{4'hF}});
    check("rst_count", count, 0);
    check("rst_dirty", dirty, 0);
    #2 reset = 1'b0;
    step();
    @(negedge clk);
    check("rst_ready_high", bus.req_ready, 1);
    step();
  endtask

  // Commit becomes visible at the third falling edge after vblank is raised.
  task automatic commit_pulse(input logic [BufW-1:0] exp);
    exp_q.push_back(exp);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    check("commit_latency", numbers, exp);
    check("commit_dirty", dirty, 0);
    step();
    vblank = 1'b0;
    step();
  endtask

  initial begin
    bit acc;
    bit ready_seen;
    reset         = 1'b1;
    vblank        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_code  = 4'h0;
    step();

    // Basic append and commit
    do_reset();
    append(4'h1);
    append(4'h2);
    append(4'hA);
    append(4'h3);
    @(negedge clk);
    check("t1_count", count, 4);
    check("t1_dirty", dirty, 1);
    check("t1_numbers_blank", numbers, {96{4'hF}});
    step();
    commit_pulse({{92{4'hF}}, 16'h3A21});

    // Fill to capacity, overflow request dropped
    do_reset();
    for (int i = 0; i < 96; i++) append(4'h7);
    @(negedge clk);
    check("t2_full", full, 1);
    check("t2_count", count, 96);
    step();
    send(2'b00, 4'h5, acc);
    @(negedge clk);
    check("t2_drop_accepted", acc, 1);
    check("t2_drop_count", count, 96);
    check("t2_drop_full", full, 1);
    step();
    commit_pulse({96{4'h7}});

    // Backspace and underflow protection
    do_reset();
    append(4'h1);
    append(4'h2);
    append(4'h3);
    backspace();
    backspace();
    @(negedge clk);
    check("t3_count1", count, 1);
    step();
    commit_pulse({{95{4'hF}}, 4'h1});
    backspace();
    backspace();
    backspace();
    @(negedge clk);
    check("t3_count0", count, 0);
    check("t3_not_full", full, 0);
    check("t3_dirty", dirty, 1);
    step();

    // Clear with vblank rising mid-clear
    do_reset();
    for (int i = 0; i < 10; i++) append(4'h2);
    commit_pulse({{86{4'hF}}, {10{4'h2}}});
    exp_q.push_back({96{4'hF}});
    send(2'b10, 4'h0, acc);
    ready_seen = 1'b0;
    for (int k = 1; k <= 96; k++) begin
      @(negedge clk);
      if (bus.req_ready) ready_seen = 1'b1;
      if (k == 5) vblank = 1'b1;
    end
    check("t4_busy_ready_low", ready_seen, 0);
    @(negedge clk);
    check("t4_commit_ready_low", bus.req_ready, 0);
    check("t4_commit_dirty", dirty, 1);
    @(negedge clk);
    check("t4_numbers_blank", numbers, {96{4'hF}});
    check("t4_count", count, 0);
    check("t4_dirty", dirty, 0);
    check("t4_ready", bus.req_ready, 1);
    step();
    vblank = 1'b0;
    step();

    // Request colliding with a vblank rise
    do_reset();
    append(4'h4);
    exp_q.push_back({{95{4'hF}}, 4'h4});
    vblank        = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_cmd   = 2'b00;
    bus.req_code  = 4'h9;
    @(negedge clk);
    check("t5_rise_ready", bus.req_ready, 0);
    @(negedge clk);
    check("t5_commit_ready", bus.req_ready, 0);
    @(negedge clk);
    check("t5_post_ready", bus.req_ready, 1);
    check("t5_post_dirty", dirty, 0);
    check("t5_post_count", count, 1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("t5_append_count", count, 2);
    check("t5_append_dirty", dirty, 1);
    step();
    vblank = 1'b0;
    step();
    commit_pulse({{94{4'hF}}, 8'h94});

    // Asynchronous reset mid-clear
    do_reset();
    append(4'h1);
    append(4'h2);
    append(4'h3);
    commit_pulse({{93{4'hF}}, 12'h321});
    send(2'b10, 4'h0, acc);
    repeat (41) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_async_numbers", numbers, {96{4'hF}});
    check("t6_async_count", count, 0);
    check("t6_async_dirty", dirty, 0);
    check("t6_async_ready", bus.req_ready, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_release_ready", bus.req_ready, 1);
    check("t6_release_numbers", numbers, {96{4'hF}});
    step();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_commits: got %0d outstanding expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_buffer_ctrl.md
Name: display_buffer_ctrl

Overview:
- Sequences updates to the on-screen symbol buffer that drives the VGA text picture generator.
- Accepts symbol and command requests from the stack calculator core through a valid/ready handshake and edits a shadow buffer.
- Copies the shadow buffer to the displayed buffer only at the start of vertical blanking, so a frame never shows a half-written line.

Parameters:
- MAX_SYMBOLS, 96, buffer capacity in 4-bit symbols.
- CNT_W, 7, width of the symbol count; must satisfy 2^CNT_W > MAX_SYMBOLS.
- BLANK_CODE, 4'hF, code stored in empty slots.

Ports:
- clk  input  1  system/pixel clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_cmd  input  2  request type: 00 append, 01 backspace, 10 clear, 11 reserved (treated as no-op).
- req_code  input  4  symbol for append: 0-9 digits, A=+, B=-, C=*, D=/, E==.
- vblank  input  1  level, high during vertical blanking.
- numbers  output  4*MAX_SYMBOLS  displayed buffer; symbol i is at bits [4i+3:4i].
- count  output  CNT_W  number of valid symbols in the shadow buffer.
- full  output  1  count == MAX_SYMBOLS.
- dirty  output  1  shadow buffer differs from the displayed buffer (pending commit).

Behaviour:
- Reset (asynchronous, any state): all slots of both buffers = BLANK_CODE; count=0; dirty=0; state=IDLE; req_ready=0 during reset and 1 in the first cycle after release.
- Handshake: a request is accepted on a rising clk edge where req_valid && req_ready. req_ready is high only in IDLE. The requester holds req_valid, req_cmd and req_code stable until accepted.
- States: IDLE, CLEAR, COMMIT.
- IDLE, append:
  - If count < MAX_SYMBOLS: shadow[count] <= req_code; count++; dirty<=1. Single cycle; the state stays IDLE.
  - If full: the request is accepted and dropped; count and dirty are unchanged.
- IDLE, backspace:
  - If count > 0: shadow[count-1] <= BLANK_CODE; count--; dirty<=1.
  - If count == 0: no-op. The count never wraps.
- IDLE, clear: go to CLEAR with idx=0. CLEAR writes BLANK_CODE to shadow[idx], one slot per cycle, for idx = 0..MAX_SYMBOLS-1. After the last write: count=0, dirty=1, return to IDLE. Total busy time is MAX_SYMBOLS cycles.
- vblank edge detect: vblank is registered once; rise = vblank && !vblank_q.
- Commit:
  - On rise, with state==IDLE and dirty==1: go to COMMIT. COMMIT lasts one cycle: numbers <= shadow; dirty<=0; return to IDLE.
  - A request valid in the same cycle as rise is not accepted; commit has priority and req_ready is deasserted in COMMIT.
- rise during CLEAR: a pending_commit flag is set. Commit runs in the cycle after CLEAR ends, before any new request is accepted.
- Missed rise: if rise occurs while dirty==0, nothing happens. A later edit waits for the next rise. numbers never changes outside COMMIT.
- Latency: an accepted edit is visible on numbers on the cycle after the next qualifying vblank rise plus one.
- Mid-operation reset: an asynchronous assertion during CLEAR or COMMIT forces the full reset state immediately. No partial commit survives.
- Widths: count comparisons are unsigned CNT_W-bit. The slot index for an append is count; for a backspace it is count-1, computed only when count>0.

Test Plan:
- Reset then append 1,2,+,3 (codes 1,2,A,3) with vblank low:
  - count=4, dirty=1, numbers all 4'hF.
  - Pulse vblank high: two cycles after the rising edge, numbers[15:0]=16'h3A21, dirty=0.
- Append 96 symbols of 4'h7, then append 4'h5:
  - full=1, count=96, the 97th request is accepted and dropped.
  - After commit, every slot reads 4'h7.
- From count=3 (codes 1,2,3): issue two backspaces then commit → count=1, numbers[11:0]=12'hFF1. Then three more backspaces → count stays 0, no underflow.
- Fill 10 symbols, issue clear, and raise vblank 5 cycles into CLEAR:
  - req_ready=0 for 96 cycles.
  - Commit occurs the cycle after CLEAR exits; numbers is all 4'hF, count=0.
- Assert req_valid with append 4'h9 in the same cycle as a vblank rise while dirty=1: commit executes first with the old contents; the append is accepted the following cycle and dirty returns to 1.
- Assert reset asynchronously mid-CLEAR (idx=40): outputs go to reset values immediately without waiting for a clock edge; req_ready=1 on the first clock after release.
